// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic GEMM engine: C = A*B or C += A*B, runtime inner dimension k.
// Optional macro ACC_SAT_EN: saturating accumulation with a sticky ovf flag (otherwise wrap, ovf=0).
module systolic_mm_engine #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned KMAX = 16,
  parameter int unsigned W    = 16,
  parameter int unsigned ACCW = 2*W + $clog2(KMAX),
  localparam int unsigned KW   = $clog2(KMAX+1),
  localparam int unsigned LDAW = $clog2(((ROWS > COLS) ? ROWS : COLS) * KMAX),
  localparam int unsigned RDAW = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KW-1:0]   cfg_k,
  input  logic            cfg_acc,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            ovf,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [LDAW-1:0] ld_addr,
  input  logic [W-1:0]    ld_data,
  input  logic [RDAW-1:0] rd_addr,
  output logic [ACCW-1:0] rd_data
);
  localparam int unsigned A_DEPTH = ROWS*KMAX;
  localparam int unsigned B_DEPTH = KMAX*COLS;
  localparam int unsigned AIW     = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int unsigned BIW     = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int unsigned CNTW    = $clog2(KMAX+ROWS+COLS);
  localparam int unsigned PW      = 2*W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            acc_mode_q, acc_mode_d;
  logic            err_q, err_d;
  logic            cfg_ok;
  logic            clr_ovf;
  logic [ACCW-1:0] rd_q, rd_d;

  logic signed [W-1:0]    a_buf [A_DEPTH];
  logic signed [W-1:0]    b_buf [B_DEPTH];
  logic signed [W-1:0]    a_pipe_q [ROWS][COLS];
  logic signed [W-1:0]    b_pipe_q [ROWS][COLS];
  logic signed [W-1:0]    a_in [ROWS][COLS];
  logic signed [W-1:0]    b_in [ROWS][COLS];
  logic signed [ACCW-1:0] acc_q [ROWS][COLS];
  logic signed [ACCW-1:0] acc_d [ROWS][COLS];
  logic [ROWS*COLS-1:0]   clamp_vec;
  logic [ACCW-1:0]        c_flat [2**RDAW];

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign ld_ready = ~busy;
  assign rd_data  = rd_q;
  assign cfg_ok   = (cfg_k != '0) && (32'(cfg_k) <= KMAX);

  // Run control: counter spans the k feed slots plus the array skew.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_mode_d = acc_mode_q;
    err_d      = 1'b0;
    clr_ovf    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            k_d        = cfg_k;
            acc_mode_d = cfg_acc;
            clr_ovf    = ~cfg_acc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (32'(cnt_q) == 32'(k_q) + ROWS + COLS - 32'd2) state_d = S_DONE;
        else cnt_d = cnt_q + CNTW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Skewed edge feed: row r / column c see operand kk = cnt - r / cnt - c.
  always_comb begin
    int kk;
    kk = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        a_in[r][c] = (c > 0) ? a_pipe_q[r][(c > 0) ? c-1 : 0] : '0;
        b_in[r][c] = (r > 0) ? b_pipe_q[(r > 0) ? r-1 : 0][c] : '0;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      kk = int'(cnt_q) - r;
      if (kk >= 0 && kk < int'(k_q)) a_in[r][0] = a_buf[AIW'(r*KMAX + kk)];
    end
    for (int c = 0; c < COLS; c++) begin
      kk = int'(cnt_q) - c;
      if (kk >= 0 && kk < int'(k_q)) b_in[0][c] = b_buf[BIW'(kk*COLS + c)];
    end
  end

  // Per-PE multiply-accumulate; a non-accumulating run starts from zero on counter 0.
  always_comb begin
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] base;
`ifdef ACC_SAT_EN
    logic signed [ACCW:0]   sum;
    sum = '0;
`endif
    prod      = '0;
    base      = '0;
    clamp_vec = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod = PW'(a_in[r][c]) * PW'(b_in[r][c]);
        base = (cnt_q == '0 && !acc_mode_q) ? '0 : acc_q[r][c];
`ifdef ACC_SAT_EN
        sum = (ACCW+1)'(base) + (ACCW+1)'(ACCW'(prod));
        if (sum[ACCW] != sum[ACCW-1]) begin
          clamp_vec[r*COLS + c] = 1'b1;
          acc_d[r][c] = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
          acc_d[r][c] = sum[ACCW-1:0];
        end
`else
        acc_d[r][c] = base + ACCW'(prod);
`endif
      end
    end
  end

  // Registered read port; out-of-range indices fall on zero-filled slots.
  always_comb begin
    for (int i = 0; i < 2**RDAW; i++) c_flat[i] = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        c_flat[RDAW'(r*COLS + c)] = acc_q[r][c];
    rd_d = busy ? '0 : c_flat[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      acc_mode_q <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pipe_q[r][c] <= '0;
          b_pipe_q[r][c] <= '0;
          acc_q[r][c]    <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      acc_mode_q <= acc_mode_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pipe_q[r][c] <= busy ? a_in[r][c] : '0;
          b_pipe_q[r][c] <= busy ? b_in[r][c] : '0;
          if (busy) acc_q[r][c] <= acc_d[r][c];
        end
      end
    end
  end

`ifdef ACC_SAT_EN
  logic ovf_q;
  assign ovf = ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (busy && |clamp_vec) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

  // Operand buffers are not reset; writes are blocked while a run is in flight.
  always_ff @(posedge clk) begin
    if (ld_valid && !busy) begin
      if (!ld_sel && 32'(ld_addr) < A_DEPTH) a_buf[AIW'(ld_addr)] <= ld_data;
      if (ld_sel && 32'(ld_addr) < B_DEPTH)  b_buf[BIW'(ld_addr)] <= ld_data;
    end
  end
endmodule
